// File: rtl/osc_pkg.sv
// Shared constants and types for the multi-channel oscillator bank.
package osc_pkg;

  localparam int OSC_WIDTH_DEFAULT  = 16;
  localparam int OSC_NUM_CH_DEFAULT = 4;
  localparam int CLK_HZ             = 10_000_000;

  typedef logic [OSC_WIDTH_DEFAULT-1:0] osc_word_t;

  // Divider giving concert A (440 Hz) from the 10 MHz system clock.
  localparam osc_word_t DIV_A4 = osc_word_t'(22727);

endpackage

// File: rtl/osc_channel.sv
// One oscillator voice: phase counter, active divider latched at period
// start, wrap tick and a 50 % square wave derived from the latched period.
module osc_channel
  import osc_pkg::*;
#(
  parameter int WIDTH = OSC_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [WIDTH-1:0] divider_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             wave_o
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] divAct_q, divAct_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] divSafe;
  logic [WIDTH-1:0] effDiv;
  logic [WIDTH:0]   halfDiv;

  // A zero divider behaves as one; a new divider is only honoured at period start.
  assign divSafe = (divider_i == '0) ? ONE : divider_i;
  assign effDiv  = (count_q == ONE) ? divSafe : divAct_q;

  // Next-state: sync forces phase restart, enable advances or wraps, otherwise hold.
  always_comb begin
    count_d  = count_q;
    divAct_d = divAct_q;
    tick_d   = 1'b0;
    if (en_i) begin
      divAct_d = effDiv;
    end
    if (sync_i) begin
      count_d = ONE;
    end else if (en_i) begin
      if (count_q == effDiv) begin
        count_d = ONE;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // Channel state registers, returning to phase 1 with a unit period on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= ONE;
      divAct_q <= ONE;
      tick_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      divAct_q <= divAct_d;
      tick_q   <= tick_d;
    end
  end

  // Half period rounded up, one bit wider so the maximum divider cannot overflow.
  assign halfDiv = ({1'b0, divAct_q} + ONE_EXT) >> 1;

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign wave_o  = ({1'b0, count_q} <= halfDiv);

endmodule

// File: rtl/osc_bank.sv
// Bank of independent oscillator channels sharing only clock and reset;
// dividers and counts are packed per channel as [k*WIDTH +: WIDTH].
module osc_bank
  import osc_pkg::*;
#(
  parameter int NUM_CH = OSC_NUM_CH_DEFAULT,
  parameter int WIDTH  = OSC_WIDTH_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       sync_i,
  input  logic [NUM_CH*WIDTH-1:0] divider_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       wave_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    osc_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[gi]),
      .sync_i    (sync_i[gi]),
      .divider_i (divider_i[gi*WIDTH +: WIDTH]),
      .count_o   (count_o[gi*WIDTH +: WIDTH]),
      .tick_o    (tick_o[gi]),
      .wave_o    (wave_o[gi])
    );
  end

endmodule

// File: tb/tb_osc_bank.sv
// Self-checking bench for osc_bank: directed scenarios plus randomized
// traffic compared against a period-based behavioural model.
module tb_osc_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       en = '0;
  logic [NUM_CH-1:0]       sync = '0;
  logic [NUM_CH*WIDTH-1:0] divider = '0;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       wave;

  int vectors = 0;
  int miscompares = 0;

  // Model: position within the current period and that period's length.
  int mCount[NUM_CH];
  int mPeriod[NUM_CH];
  bit mTick[NUM_CH];

  osc_bank #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .sync_i    (sync),
    .divider_i (divider),
    .count_o   (count),
    .tick_o    (tick),
    .wave_o    (wave)
  );

  // 10 MHz system clock.
  always #50 clk = ~clk;

  function automatic int cnt(int ch);
    return int'(count[ch*WIDTH +: WIDTH]);
  endfunction

  function automatic int divOf(int ch);
    int d;
    d = int'(divider[ch*WIDTH +: WIDTH]);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic setDiv(int ch, int val);
    divider[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mCount[ch]  = 1;
      mPeriod[ch] = 1;
      mTick[ch]   = 1'b0;
    end
  endtask

  // Advance one clock: model updates at the rising edge, control returns at
  // the following falling edge where outputs are checked and inputs driven.
  task automatic step();
    @(posedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sync[ch]) begin
        mCount[ch] = 1;
        mTick[ch]  = 1'b0;
      end else if (en[ch]) begin
        if (mCount[ch] == 1) mPeriod[ch] = divOf(ch);
        mCount[ch] = mCount[ch] % mPeriod[ch] + 1;
        mTick[ch]  = (mCount[ch] == 1);
      end else begin
        mTick[ch] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = '0;
    sync = '0;
    #10;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) setDiv(ch, 1000);
    en = '1;
    repeat (499) step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      vectors++;
      if (cnt(ch) !== 500) begin
        miscompares++;
        $display("[TB] FAIL reset_precount ch%0d: got %0d expected 500", ch, cnt(ch));
      end
    end
    #20;
    rst = 1'b1;
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      vectors++;
      if (cnt(ch) !== 1 || tick[ch] !== 1'b0 || wave[ch] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_async ch%0d: got count=%0d tick=%b wave=%b expected 1/0/1",
                 ch, cnt(ch), tick[ch], wave[ch]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = '0;
    for (int n = 0; n < 3; n++) begin
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        vectors++;
        if (cnt(ch) !== 1 || tick[ch] !== 1'b0 || wave[ch] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL reset_hold ch%0d cyc%0d: got count=%0d tick=%b wave=%b expected 1/0/1",
                   ch, n, cnt(ch), tick[ch], wave[ch]);
        end
      end
    end
  endtask

  task automatic test_a4_rollover();
    int errs;
    do_reset();
    divider = '0;
    setDiv(0, 22727);
    en = 4'b0001;
    step();
    vectors++;
    if (cnt(0) !== 2 || tick[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL a4_first: got count=%0d tick=%b expected 2/0", cnt(0), tick[0]);
    end
    errs = 0;
    for (int i = 3; i <= 22727; i++) begin
      step();
      if (cnt(0) !== i || tick[0] !== 1'b0 || wave[0] !== (i <= 11364)) errs++;
    end
    vectors++;
    if (errs != 0 || cnt(0) !== 22727) begin
      miscompares++;
      $display("[TB] FAIL a4_ramp: got %0d bad cycles, final count=%0d expected 0 bad, 22727",
               errs, cnt(0));
    end
    step();
    vectors++;
    if (cnt(0) !== 1 || tick[0] !== 1'b1 || wave[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL a4_wrap: got count=%0d tick=%b wave=%b expected 1/1/1",
               cnt(0), tick[0], wave[0]);
    end
    step();
    vectors++;
    if (cnt(0) !== 2 || tick[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL a4_after_wrap: got count=%0d tick=%b expected 2/0", cnt(0), tick[0]);
    end
  endtask

  task automatic test_retune();
    int ticks;
    do_reset();
    divider = '0;
    setDiv(0, 30000);
    en = 4'b0001;
    repeat (99) step();
    vectors++;
    if (cnt(0) !== 100) begin
      miscompares++;
      $display("[TB] FAIL retune_pre: got %0d expected 100", cnt(0));
    end
    setDiv(0, 1000);
    ticks = 0;
    repeat (29900) begin
      step();
      if (tick[0] === 1'b1) ticks++;
    end
    vectors++;
    if (cnt(0) !== 30000 || ticks != 0) begin
      miscompares++;
      $display("[TB] FAIL retune_old_period: got count=%0d ticks=%0d expected 30000/0", cnt(0), ticks);
    end
    step();
    vectors++;
    if (cnt(0) !== 1 || tick[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL retune_wrap1: got count=%0d tick=%b expected 1/1", cnt(0), tick[0]);
    end
    ticks = 0;
    repeat (999) begin
      step();
      if (tick[0] === 1'b1) ticks++;
    end
    vectors++;
    if (cnt(0) !== 1000 || ticks != 0) begin
      miscompares++;
      $display("[TB] FAIL retune_new_period: got count=%0d ticks=%0d expected 1000/0", cnt(0), ticks);
    end
    step();
    vectors++;
    if (cnt(0) !== 1 || tick[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL retune_wrap2: got count=%0d tick=%b expected 1/1", cnt(0), tick[0]);
    end
  endtask

  task automatic test_sync();
    do_reset();
    divider = '0;
    setDiv(1, 8000);
    en = 4'b0010;
    repeat (4999) step();
    vectors++;
    if (cnt(1) !== 5000) begin
      miscompares++;
      $display("[TB] FAIL sync_pre: got %0d expected 5000", cnt(1));
    end
    sync = 4'b0010;
    step();
    sync = '0;
    vectors++;
    if (cnt(1) !== 1 || tick[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sync_mid: got count=%0d tick=%b expected 1/0", cnt(1), tick[1]);
    end
    setDiv(1, 10);
    repeat (9) step();
    vectors++;
    if (cnt(1) !== 10) begin
      miscompares++;
      $display("[TB] FAIL sync_pre_wrap: got %0d expected 10", cnt(1));
    end
    sync = 4'b0010;
    step();
    sync = '0;
    vectors++;
    if (cnt(1) !== 1 || tick[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sync_on_wrap: got count=%0d tick=%b expected 1/0", cnt(1), tick[1]);
    end
    step();
    vectors++;
    if (cnt(1) !== 2) begin
      miscompares++;
      $display("[TB] FAIL sync_resume: got %0d expected 2", cnt(1));
    end
  endtask

  task automatic test_edge_dividers();
    int vals[2];
    vals[0] = 1;
    vals[1] = 0;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int ch = 0; ch < NUM_CH; ch++) setDiv(ch, vals[v]);
      en = '1;
      for (int n = 0; n < 4; n++) begin
        step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
          vectors++;
          if (cnt(ch) !== 1 || tick[ch] !== 1'b1 || wave[ch] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL edge_div%0d ch%0d: got count=%0d tick=%b wave=%b expected 1/1/1",
                     vals[v], ch, cnt(ch), tick[ch], wave[ch]);
          end
        end
      end
      en = '0;
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        vectors++;
        if (cnt(ch) !== 1 || tick[ch] !== 1'b0 || wave[ch] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL edge_div%0d_idle ch%0d: got count=%0d tick=%b wave=%b expected 1/0/1",
                   vals[v], ch, cnt(ch), tick[ch], wave[ch]);
        end
      end
    end
  endtask

  task automatic test_independence();
    int d[NUM_CH];
    d[0] = 3; d[1] = 4; d[2] = 5; d[3] = 7;
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) setDiv(ch, d[ch]);
    en = '1;
    for (int n = 1; n <= 42; n++) begin
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        vectors++;
        if (tick[ch] !== ((n % d[ch]) == 0) || cnt(ch) !== (n % d[ch]) + 1) begin
          miscompares++;
          $display("[TB] FAIL indep ch%0d cyc%0d: got count=%0d tick=%b expected %0d/%0b",
                   ch, n, cnt(ch), tick[ch], (n % d[ch]) + 1, (n % d[ch]) == 0);
        end
      end
    end
    en = 4'b1011;
    for (int n = 43; n <= 52; n++) begin
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int expC;
        bit expT;
        expC = (ch == 2) ? (42 % 5) + 1 : (n % d[ch]) + 1;
        expT = (ch == 2) ? 1'b0 : ((n % d[ch]) == 0);
        vectors++;
        if (cnt(ch) !== expC || tick[ch] !== expT) begin
          miscompares++;
          $display("[TB] FAIL indep_freeze ch%0d cyc%0d: got count=%0d tick=%b expected %0d/%0b",
                   ch, n, cnt(ch), tick[ch], expC, expT);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH*WIDTH-1:0] expCount;
    logic [NUM_CH-1:0]       expTick;
    logic [NUM_CH-1:0]       expWave;
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) setDiv(ch, $urandom_range(0, 12));
    for (int n = 0; n < 3000; n++) begin
      en   = NUM_CH'($urandom);
      sync = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 7) == 0) setDiv(ch, $urandom_range(0, 12));
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        expCount[ch*WIDTH +: WIDTH] = WIDTH'(mCount[ch]);
        expTick[ch] = mTick[ch];
        expWave[ch] = (mCount[ch] <= (mPeriod[ch] + 1) / 2);
      end
      vectors++;
      if (count !== expCount) begin
        miscompares++;
        $display("[TB] FAIL rand_count cyc%0d: got %h expected %h", n, count, expCount);
      end
      vectors++;
      if (tick !== expTick) begin
        miscompares++;
        $display("[TB] FAIL rand_tick cyc%0d: got %b expected %b", n, tick, expTick);
      end
      vectors++;
      if (wave !== expWave) begin
        miscompares++;
        $display("[TB] FAIL rand_wave cyc%0d: got %b expected %b", n, wave, expWave);
      end
    end
    en   = '0;
    sync = '0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_a4_rollover();
    test_retune();
    test_sync();
    test_edge_dividers();
    test_independence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
